// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pending_ctrl
//  Brief    : Captures request lines into a pending register, masks them,
//             presents the highest-index eligible request as an ID under a
//             valid/ready handshake and holds it in-service until EOI.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int EDGE_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic             irq_valid_o,
    input  logic             irq_ready_i,
    output logic [ID_W-1:0]  irq_id_o,
    output logic             in_service_o,
    input  logic             eoi_i,
    output logic [N_REQ-1:0] pending_o,
    output logic [N_REQ-1:0] ovf_o,
    input  logic             ovf_clr_i
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam logic [N_REQ-1:0] ONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]       state_q,      state_d;
    logic [N_REQ-1:0] pending_q,    pending_d;
    logic [N_REQ-1:0] ovf_q,        ovf_d;
    logic [ID_W-1:0]  irq_id_q,     irq_id_d;
    logic             irq_valid_q,  irq_valid_d;
    logic             in_service_q, in_service_d;

    logic [N_REQ-1:0] w_set;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_ovf_evt;
    logic [N_REQ-1:0] w_eligible;
    logic [ID_W-1:0]  w_sel;
    logic             w_accept;

    // An accept clears exactly the bit of the ID currently being presented.
    assign w_accept   = (state_q == ST_PRESENT) && irq_ready_i;
    assign w_clr      = w_accept ? (ONE_LSB << irq_id_q) : '0;
    assign w_eligible = pending_q & ~mask_i;

    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic [N_REQ-1:0] req_prev_q;

            // Previous request sample; cleared on reset so a request already
            // high at reset release is treated as a fresh edge.
            always_ff @(posedge clk) begin
                if (!rst_n) req_prev_q <= '0;
                else        req_prev_q <= req_i;
            end

            assign w_set     = req_i & ~req_prev_q;
            assign w_ovf_evt = w_set & pending_q & ~w_clr;
        end else begin : g_level
            // A held level re-sets pending every cycle, so overflow is meaningless.
            assign w_set     = req_i;
            assign w_ovf_evt = '0;
        end
    endgenerate

    // Highest-index eligible request wins; the later loop iteration overrides.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_eligible[i]) w_sel = ID_W'(i);
        end
    end

    // Pending and sticky overflow next-state; a set beats a same-cycle clear,
    // and a new overflow event beats ovf_clr.
    always_comb begin
        pending_d = w_set | (pending_q & ~w_clr);
        ovf_d     = w_ovf_evt | (ovf_q & ~{N_REQ{ovf_clr_i}});
    end

    // Handshake FSM; outputs are computed here and registered below.
    always_comb begin
        state_d      = state_q;
        irq_id_d     = irq_id_q;
        irq_valid_d  = irq_valid_q;
        in_service_d = in_service_q;
        case (state_q)
            ST_IDLE: begin
                irq_valid_d  = 1'b0;
                in_service_d = 1'b0;
                if (|w_eligible) begin
                    irq_id_d    = w_sel;
                    irq_valid_d = 1'b1;
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                // irq_id stays frozen here regardless of new requests or mask.
                if (irq_ready_i) begin
                    irq_valid_d  = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (eoi_i) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                irq_valid_d  = 1'b0;
                in_service_d = 1'b0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            ovf_q        <= '0;
            irq_id_q     <= '0;
            irq_valid_q  <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            irq_id_q     <= irq_id_d;
            irq_valid_q  <= irq_valid_d;
            in_service_q <= in_service_d;
        end
    end

    assign irq_valid_o  = irq_valid_q;
    assign irq_id_o     = irq_id_q;
    assign in_service_o = in_service_q;
    assign pending_o    = pending_q;
    assign ovf_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_pending_ctrl
//  Brief    : Vector-table bench for irq_pending_ctrl, edge and level modes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] mask;
        logic       rdy;
        logic       eoi;
        logic       oclr;
        logic       v;
        logic [1:0] id;
        logic       ins;
        logic [3:0] pend;
        logic [3:0] ovf;
    } vec_t;

    typedef struct {
        bit         lvl;
        int         idx;
        logic       v;
        logic [1:0] id;
        logic       ins;
        logic [3:0] pend;
        logic [3:0] ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-mode instance signals
    logic       rst_n_e = 1'b0;
    logic [3:0] req_e = '0, mask_e = '0;
    logic       rdy_e = 1'b0, eoi_e = 1'b0, oclr_e = 1'b0;
    logic       valid_e, ins_e;
    logic [1:0] id_e;
    logic [3:0] pend_e, ovf_e;

    // Level-mode instance signals
    logic       rst_n_l = 1'b0;
    logic [3:0] req_l = '0, mask_l = '0;
    logic       rdy_l = 1'b0, eoi_l = 1'b0, oclr_l = 1'b0;
    logic       valid_l, ins_l;
    logic [1:0] id_l;
    logic [3:0] pend_l, ovf_l;

    int checks   = 0;
    int failures = 0;

    vec_t tbl_e[$];
    vec_t tbl_l[$];
    exp_t sb[$];

    irq_pending_ctrl #(.N_REQ(4), .ID_W(2), .EDGE_MODE(1)) u_dut_edge (
        .clk(clk), .rst_n(rst_n_e), .req_i(req_e), .mask_i(mask_e),
        .irq_valid_o(valid_e), .irq_ready_i(rdy_e), .irq_id_o(id_e),
        .in_service_o(ins_e), .eoi_i(eoi_e), .pending_o(pend_e),
        .ovf_o(ovf_e), .ovf_clr_i(oclr_e)
    );

    irq_pending_ctrl #(.N_REQ(4), .ID_W(2), .EDGE_MODE(0)) u_dut_level (
        .clk(clk), .rst_n(rst_n_l), .req_i(req_l), .mask_i(mask_l),
        .irq_valid_o(valid_l), .irq_ready_i(rdy_l), .irq_id_o(id_l),
        .in_service_o(ins_l), .eoi_i(eoi_l), .pending_o(pend_l),
        .ovf_o(ovf_l), .ovf_clr_i(oclr_l)
    );

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] mk_,
                                input logic rd, input logic eo, input logic oc,
                                input logic v, input logic [1:0] id, input logic ins,
                                input logic [3:0] p, input logic [3:0] o);
        vec_t t;
        t.rst_n = r;  t.req = rq; t.mask = mk_; t.rdy = rd; t.eoi = eo; t.oclr = oc;
        t.v = v; t.id = id; t.ins = ins; t.pend = p; t.ovf = o;
        return t;
    endfunction

    // Pops the oldest expectation and compares it with the selected instance.
    task automatic check_front();
        exp_t e;
        logic       av, ai;
        logic [1:0] aid;
        logic [3:0] ap, ao;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb.pop_front();
        if (e.lvl) begin av = valid_l; aid = id_l; ai = ins_l; ap = pend_l; ao = ovf_l; end
        else       begin av = valid_e; aid = id_e; ai = ins_e; ap = pend_e; ao = ovf_e; end
        if ({av, aid, ai, ap, ao} !== {e.v, e.id, e.ins, e.pend, e.ovf}) begin
            failures++;
            $display("FAIL %s[%0d]: got valid=%b id=%0d insvc=%b pend=%b ovf=%b, want valid=%b id=%0d insvc=%b pend=%b ovf=%b",
                     e.lvl ? "level" : "edge", e.idx, av, aid, ai, ap, ao,
                     e.v, e.id, e.ins, e.pend, e.ovf);
        end
    endtask

    task automatic apply(input vec_t t, input bit lvl, input int idx);
        exp_t e;
        @(negedge clk);
        if (lvl) begin
            rst_n_l = t.rst_n; req_l = t.req; mask_l = t.mask;
            rdy_l = t.rdy; eoi_l = t.eoi; oclr_l = t.oclr;
        end else begin
            rst_n_e = t.rst_n; req_e = t.req; mask_e = t.mask;
            rdy_e = t.rdy; eoi_e = t.eoi; oclr_e = t.oclr;
        end
        e.lvl = lvl; e.idx = idx; e.v = t.v; e.id = t.id; e.ins = t.ins;
        e.pend = t.pend; e.ovf = t.ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, want finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        // rst req mask rdy eoi oclr | valid id insvc pending ovf
        // reset state
        tbl_e.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        // single request, accept on first presented cycle, eoi later
        tbl_e.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 0, 0, 2'd0, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd2, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd2, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd2, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd2, 0, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd2, 0, 4'b0000, 4'b0000));
        // three simultaneous requests served 3, 1, 0
        tbl_e.push_back(mk(1, 4'b1011, 4'b0000, 0, 0, 0, 0, 2'd2, 0, 4'b1011, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd3, 0, 4'b1011, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd3, 1, 4'b0011, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd3, 0, 4'b0011, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 1, 2'd1, 0, 4'b0011, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd1, 1, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd1, 0, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd0, 0, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd0, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        // masked high request waits; unmask presents it
        tbl_e.push_back(mk(1, 4'b1001, 4'b1000, 0, 0, 0, 0, 2'd0, 0, 4'b1001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b1000, 0, 0, 0, 1, 2'd0, 0, 4'b1001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b1000, 1, 0, 0, 0, 2'd0, 1, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b1000, 0, 1, 0, 0, 2'd0, 0, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b1000, 0, 0, 0, 0, 2'd0, 0, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd3, 0, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd3, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd3, 0, 4'b0000, 4'b0000));
        // presented ID frozen while higher request arrives and mask changes
        tbl_e.push_back(mk(1, 4'b0010, 4'b0000, 0, 0, 0, 0, 2'd3, 0, 4'b0010, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000));
        tbl_e.push_back(mk(1, 4'b1000, 4'b0000, 0, 0, 0, 1, 2'd1, 0, 4'b1010, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0010, 0, 0, 0, 1, 2'd1, 0, 4'b1010, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd1, 1, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd1, 0, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd3, 0, 4'b1000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd3, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd3, 0, 4'b0000, 4'b0000));
        // overflow on masked pending bit, clear, event beats clear
        tbl_e.push_back(mk(1, 4'b0100, 4'b0100, 0, 0, 0, 0, 2'd3, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0100, 0, 0, 0, 0, 2'd3, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0100, 4'b0100, 0, 0, 0, 0, 2'd3, 0, 4'b0100, 4'b0100));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0100, 0, 0, 1, 0, 2'd3, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0100, 4'b0100, 0, 0, 1, 0, 2'd3, 0, 4'b0100, 4'b0100));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0100, 0, 0, 1, 0, 2'd3, 0, 4'b0100, 4'b0000));
        // new edge on the accept cycle: pending stays, no overflow
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0100, 4'b0000, 1, 0, 0, 0, 2'd2, 1, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd2, 0, 4'b0100, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd2, 0, 4'b0100, 4'b0000));
        // reset during PRESENT
        tbl_e.push_back(mk(0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        // reset during SERVICE with req held; held req counts as edge on release
        tbl_e.push_back(mk(1, 4'b0001, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0001, 4'b0000, 0, 0, 0, 1, 2'd0, 0, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0001, 4'b0000, 1, 0, 0, 0, 2'd0, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(0, 4'b0001, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0001, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd0, 0, 4'b0001, 4'b0000));
        // eoi while presenting is ignored
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 1, 2'd0, 0, 4'b0001, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd0, 1, 4'b0000, 4'b0000));
        tbl_e.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));

        // Level mode: held request re-presented after each eoi
        tbl_l.push_back(mk(0, 4'b0010, 4'b0000, 0, 0, 0, 0, 2'd0, 0, 4'b0000, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 0, 0, 2'd0, 0, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 0, 0, 2'd1, 1, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 0, 0, 2'd1, 0, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 1, 0, 0, 0, 2'd1, 1, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0010, 4'b0000, 0, 1, 0, 0, 2'd1, 0, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd1, 0, 4'b0010, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0000, 4'b0000, 1, 0, 0, 0, 2'd1, 1, 4'b0000, 4'b0000));
        tbl_l.push_back(mk(1, 4'b0000, 4'b0000, 0, 1, 0, 0, 2'd1, 0, 4'b0000, 4'b0000));

        for (int i = 0; i < tbl_e.size(); i++) apply(tbl_e[i], 1'b0, i);
        for (int i = 0; i < tbl_l.size(); i++) apply(tbl_l[i], 1'b1, i);

        // Leftover expectations mean a check was never reached.
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d leftover, want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
